// File: rtl/ppi_handshake_peer.sv
// ppi_handshake_peer: local-side peer for an 8255-style PPI port pair in mode 1.
// The transmit side presents a byte on port_out and strobes it into the PPI input
// port (stb_n), then follows ibf until the PPI has taken it. The receive side
// acknowledges bytes from the PPI output port (ack_n) into a 4-entry FIFO.
//
// Ports:
//   clock, reset_n        single clock, asynchronous active-low reset
//   tx_data/tx_valid/tx_ready  byte from the local side (valid/ready)
//   port_out, stb_n       data and input strobe toward the PPI
//   ibf                   PPI input-buffer-full flag
//   port_in, obf_n        data and output-buffer-full flag from the PPI
//   ack_n                 acknowledge toward the PPI
//   rx_data/rx_valid/rx_ready  head of the receive FIFO (valid/ready)
module ppi_handshake_peer #(
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned STB_WIDTH    = 2,
    parameter int unsigned ACK_WIDTH    = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] port_out,
    output logic       stb_n,
    input  logic       ibf,
    input  logic [7:0] port_in,
    input  logic       obf_n,
    output logic       ack_n,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready
);
    localparam int unsigned DW    = 8;
    localparam int unsigned CW    = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 2;
    localparam int unsigned NW    = 3;

    localparam logic [2:0] T_IDLE       = 3'd0;
    localparam logic [2:0] T_SETUP      = 3'd1;
    localparam logic [2:0] T_STROBE     = 3'd2;
    localparam logic [2:0] T_WAIT_FULL  = 3'd3;
    localparam logic [2:0] T_WAIT_EMPTY = 3'd4;

    localparam logic [1:0] R_IDLE         = 2'd0;
    localparam logic [1:0] R_ACK          = 2'd1;
    localparam logic [1:0] R_WAIT_RELEASE = 2'd2;

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST   = CW'(STB_WIDTH - 1);
    localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_WIDTH - 1);
    localparam logic [NW-1:0] FIFO_FULL  = NW'(DEPTH);

    logic [2:0]    t_state_q, t_state_d;
    logic [CW-1:0] t_cnt_q, t_cnt_d;
    logic [DW-1:0] port_out_d;
    logic          tx_ready_d;
    logic          stb_n_d;

    logic [1:0]    r_state_q, r_state_d;
    logic [CW-1:0] r_cnt_q, r_cnt_d;
    logic          ack_n_d;
    logic          push;
    logic          pop;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] count_q, count_d;
    logic [DW-1:0] rx_data_d;
    logic          rx_valid_d;

    // Transmit FSM next state; byte latched on the accepting handshake
    always_comb begin
        t_state_d  = t_state_q;
        t_cnt_d    = t_cnt_q;
        port_out_d = port_out;
        case (t_state_q)
            T_IDLE: begin
                if (tx_valid && tx_ready) begin
                    port_out_d = tx_data;
                    t_cnt_d    = '0;
                    t_state_d  = T_SETUP;
                end
            end
            T_SETUP: begin
                if (t_cnt_q == SETUP_LAST) begin
                    t_cnt_d   = '0;
                    t_state_d = T_STROBE;
                end else begin
                    t_cnt_d = t_cnt_q + CW'(1);
                end
            end
            T_STROBE: begin
                if (t_cnt_q == STB_LAST) begin
                    t_cnt_d   = '0;
                    t_state_d = T_WAIT_FULL;
                end else begin
                    t_cnt_d = t_cnt_q + CW'(1);
                end
            end
            T_WAIT_FULL: begin
                if (ibf) begin
                    t_state_d = T_WAIT_EMPTY;
                end
            end
            T_WAIT_EMPTY: begin
                if (!ibf) begin
                    t_state_d = T_IDLE;
                end
            end
            default: begin
                t_state_d = T_IDLE;
                t_cnt_d   = '0;
            end
        endcase
        // Outputs are registered copies of the next state's decode
        tx_ready_d = (t_state_d == T_IDLE);
        stb_n_d    = (t_state_d != T_STROBE);
    end

    // Receive FSM next state; only starts an ack when the FIFO has room
    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        push      = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (!obf_n && (count_q < FIFO_FULL)) begin
                    r_cnt_d   = '0;
                    r_state_d = R_ACK;
                end
            end
            R_ACK: begin
                if (r_cnt_q == ACK_LAST) begin
                    push      = 1'b1;
                    r_cnt_d   = '0;
                    r_state_d = R_WAIT_RELEASE;
                end else begin
                    r_cnt_d = r_cnt_q + CW'(1);
                end
            end
            R_WAIT_RELEASE: begin
                if (obf_n) begin
                    r_state_d = R_IDLE;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                r_cnt_d   = '0;
            end
        endcase
        ack_n_d = (r_state_d != R_ACK);
    end

    // FIFO pointers/count; the registered head tracks a push into an empty FIFO
    always_comb begin
        pop      = rx_valid && rx_ready;
        wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase
        rx_valid_d = (count_d != '0);
        if (push && (wr_ptr_q == rd_ptr_d)) begin
            rx_data_d = port_in;
        end else begin
            rx_data_d = mem_q[rd_ptr_d];
        end
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            t_state_q <= T_IDLE;
            t_cnt_q   <= '0;
            port_out  <= '0;
            tx_ready  <= 1'b0;
            stb_n     <= 1'b1;
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            ack_n     <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            t_state_q <= t_state_d;
            t_cnt_q   <= t_cnt_d;
            port_out  <= port_out_d;
            tx_ready  <= tx_ready_d;
            stb_n     <= stb_n_d;
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            ack_n     <= ack_n_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rx_data   <= rx_data_d;
            rx_valid  <= rx_valid_d;
            if (push) begin
                mem_q[wr_ptr_q] <= port_in;
            end
        end
    end

endmodule
